fc_layer_ctrl: RTL
==================

FC_LAYER_CTRL -- requirements
Module: fc_layer_ctrl

Interface
REQ-001 Parameter NUM_NEURONS, default 10: number of output neurons sequenced per inference (range 2..256).
REQ-002 Parameter IDX_W, default 4: width of the neuron index and ROM address; SHALL satisfy 2**IDX_W >= NUM_NEURONS.
REQ-003 Parameter TIMEOUT, default 15: maximum cycles spent in WAIT before abort.
REQ-004 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_start  input  1  begin one inference; sampled only in IDLE.
REQ-007 i_abort  input  1  synchronous abort of an inference in progress.
REQ-008 o_busy  output  1  high in every state except IDLE.
REQ-009 o_rom_addr  output  IDX_W  current neuron index, driving the weight/bias ROM (1-cycle read latency).
REQ-010 o_fc_start  output  1  one-cycle start pulse to the shared FC neuron unit.
REQ-011 i_fc_output  input  32  signed FC result.
REQ-012 i_fc_finished  input  1  FC completion pulse.
REQ-013 o_out_valid  output  1  one-cycle pulse qualifying o_out_idx/o_out_data.
REQ-014 o_out_idx  output  IDX_W  neuron index of the current result.
REQ-015 o_out_data  output  32  captured FC result.
REQ-016 o_done  output  1  one-cycle pulse at end of a complete inference.
REQ-017 o_argmax  output  IDX_W  index of the largest signed result, valid from o_done until the next i_start.
REQ-018 o_error  output  1  one-cycle pulse on timeout.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, START, WAIT, STORE, DONE; all outputs SHALL be registered.
REQ-020 IDLE: i_start=1 SHALL set idx=0, clear the argmax tracker, and go to LOAD; i_start in any other state SHALL be ignored.
REQ-021 LOAD SHALL last exactly 1 cycle (ROM latency), then go to START.
REQ-022 START SHALL assert o_fc_start for exactly 1 cycle, clear the timeout counter, and go to WAIT.
REQ-023 o_rom_addr SHALL equal idx and stay stable from LOAD through STORE of that neuron.
REQ-024 WAIT: i_fc_finished=1 SHALL capture i_fc_output into o_out_data and go to STORE; otherwise the counter increments.
REQ-025 WAIT: when the counter reaches TIMEOUT with no i_fc_finished, the FSM SHALL go to IDLE with o_error pulsed and neither o_done nor o_out_valid asserted.
REQ-026 STORE SHALL pulse o_out_valid with o_out_idx=idx, update the argmax tracker, then go to DONE if idx==NUM_NEURONS-1, else increment idx and go to LOAD.
REQ-027 The argmax update SHALL use a signed 32-bit compare: idx 0 always loads; later neurons replace only if strictly greater, so ties keep the lowest index.
REQ-028 DONE SHALL pulse o_done with o_argmax final for 1 cycle, then go to IDLE.
REQ-029 i_abort=1 in any non-IDLE state SHALL force IDLE on the next edge with no o_done, o_out_valid or o_error; i_abort has priority over i_fc_finished and timeout.
REQ-030 i_fc_finished outside WAIT SHALL be ignored.
REQ-031 Minimum per-neuron latency: LOAD+START+WAIT(>=2 with a 2-cycle FC unit)+STORE = 5 cycles; a full inference with NUM_NEURONS=10 takes 51 cycles from i_start to o_done inclusive.

Reset
REQ-032 While i_rst_n=0: state=IDLE, idx=0, counter=0, and every output=0, including o_argmax and o_out_data.
REQ-033 Reset asserted mid-inference SHALL abandon it immediately with no o_done; the next inference SHALL need a fresh i_start.

Verification
REQ-034 Results 5,-3,9,9,0,1,2,3,4,-8 with 2-cycle FC model -> ten o_out_valid pulses at idx 0..9, o_argmax=2, o_done 51 cycles after i_start.
REQ-035 All results negative (-100..-91 ascending) -> o_argmax=9; all results equal -> o_argmax=0.
REQ-036 FC model withholds i_fc_finished at neuron 4 -> o_error pulse TIMEOUT cycles after that o_fc_start, no o_done, o_busy low next cycle.
REQ-037 i_abort asserted in WAIT of neuron 3, same cycle as i_fc_finished -> no o_out_valid for idx 3, IDLE next cycle; new i_start restarts at o_rom_addr=0.
REQ-038 i_start re-pulsed while busy, and i_rst_n pulsed low in STORE -> extra start ignored; reset clears all outputs asynchronously and no o_done follows.
REQ-039 Assertions: o_fc_start never high twice without an intervening i_fc_finished or abort, and o_rom_addr is constant between LOAD and STORE.

Source files
------------

// File: rtl/fc_layer_ctrl_if.sv
// rtl/fc_layer_ctrl_if.sv - handshake between the layer sequencer and the shared FC neuron unit
//   o_fc_start    : one-cycle start pulse towards the FC unit
//   i_fc_output   : signed 32-bit FC result
//   i_fc_finished : FC completion pulse
//   master = sequencer side, slave = FC unit side
interface fc_layer_ctrl_if;
  logic        o_fc_start;
  logic [31:0] i_fc_output;
  logic        i_fc_finished;

  modport master (output o_fc_start, input i_fc_output, input i_fc_finished);
  modport slave  (input o_fc_start, output i_fc_output, output i_fc_finished);
endinterface

// File: rtl/fc_layer_ctrl.sv
// rtl/fc_layer_ctrl.sv - sequences one fully-connected layer through a shared FC neuron unit
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : begin one inference (sampled only when idle)
//   i_abort        : abandon the inference in progress
//   o_busy         : high whenever not idle
//   o_rom_addr     : current neuron index for the weight/bias ROM
//   fc             : start/result/finished handshake with the FC unit
//   o_out_valid, o_out_idx, o_out_data : per-neuron result pulse
//   o_done, o_argmax : end-of-inference pulse and winning neuron index
//   o_error        : pulse when the FC unit fails to finish in time
module fc_layer_ctrl #(
  parameter int NUM_NEURONS = 10,
  parameter int IDX_W       = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  output logic                 o_busy,
  output logic [IDX_W-1:0]     o_rom_addr,
  fc_layer_ctrl_if.master      fc,
  output logic                 o_out_valid,
  output logic [IDX_W-1:0]     o_out_idx,
  output logic [31:0]          o_out_data,
  output logic                 o_done,
  output logic [IDX_W-1:0]     o_argmax,
  output logic                 o_error
);

  localparam int               CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_NEURONS - 1);
  // The counter starts at 0 in the first WAIT cycle, so expiring at
  // TIMEOUT-2 places the error pulse TIMEOUT cycles after o_fc_start.
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 2);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_STORE, S_DONE} state_t;

  state_t           state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [31:0]      best, best_d;
  logic             fc_start_q, fc_start_d;
  logic             busy_d, valid_d, done_d, error_d;
  logic [IDX_W-1:0] out_idx_d, argmax_d;
  logic [31:0]      out_data_d;

  assign fc.o_fc_start = fc_start_q;
  assign o_rom_addr    = idx;

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    cnt_d      = cnt;
    best_d     = best;
    fc_start_d = 1'b0;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;
    out_idx_d  = o_out_idx;
    out_data_d = o_out_data;
    argmax_d   = o_argmax;
    // Abort outranks every other event, including a coincident finish.
    if (state != S_IDLE && i_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            idx_d    = '0;
            best_d   = '0;
            argmax_d = '0;
            state_d  = S_LOAD;
          end
        end
        S_LOAD: begin
          // ROM data is ready one cycle after the address settles.
          fc_start_d = 1'b1;
          state_d    = S_START;
        end
        S_START: begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (fc.i_fc_finished) begin
            out_data_d = fc.i_fc_output;
            out_idx_d  = idx;
            valid_d    = 1'b1;
            state_d    = S_STORE;
          end else if (cnt == CNT_LIMIT) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        S_STORE: begin
          // Strictly-greater replacement keeps the lowest index on ties.
          if (idx == '0 || $signed(o_out_data) > $signed(best)) begin
            best_d   = o_out_data;
            argmax_d = idx;
          end
          if (idx == LAST) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx + IDX_W'(1);
            state_d = S_LOAD;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      cnt         <= '0;
      best        <= '0;
      fc_start_q  <= 1'b0;
      o_busy      <= 1'b0;
      o_out_valid <= 1'b0;
      o_out_idx   <= '0;
      o_out_data  <= '0;
      o_done      <= 1'b0;
      o_argmax    <= '0;
      o_error     <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      cnt         <= cnt_d;
      best        <= best_d;
      fc_start_q  <= fc_start_d;
      o_busy      <= busy_d;
      o_out_valid <= valid_d;
      o_out_idx   <= out_idx_d;
      o_out_data  <= out_data_d;
      o_done      <= done_d;
      o_argmax    <= argmax_d;
      o_error     <= error_d;
    end
  end

endmodule
